decode_dispatch_ctrl: RTL and testbench

Issue-dispatch controller between the decode stage's issue outputs and the four execution pipes (ALU, MUL, MEM, BRU). Buffers decoded instructions in a small in-order FIFO and presents the head to exactly one pipe, as selected by its one-hot pipe flags, using per-pipe valid/ready handshakes. Drops everything on snoop hit or branch-correction flush, and counts dispatch stall cycles.

---
 rtl/decode_dispatch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_decode_dispatch_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_ctrl.sv
// decode_dispatch_ctrl
// In-order issue FIFO between the decode stage and the ALU/MUL/MEM/BRU pipes.
// The FIFO head is offered to the single pipe named by its one-hot pipe flags.
// A snoop hit or a branch correction empties the FIFO.
// Stall cycles (head waiting on a not-ready pipe) are counted with saturation.
// Optional macro DECODE_DISPATCH_BYPASS_EN: while the FIFO is empty, the incoming
// instruction drives the head combinationally (0-cycle latency). It is written
// into the FIFO only if its target pipe does not take it in the same cycle.
module decode_dispatch_ctrl #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        snoop_hit,
   input  logic        bco_valid,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_pc,
   input  logic [3:0]  i_rob,
   input  logic [25:0] i_imm,
   input  logic [7:0]  i_fid,
   input  logic        i_branch,
   input  logic        i_load,
   input  logic        i_store,
   input  logic [19:0] i_cmd,
   input  logic [3:0]  i_pipe,
   output logic        o_alu_valid,
   output logic        o_mul_valid,
   output logic        o_mem_valid,
   output logic        o_bru_valid,
   input  logic        o_alu_ready,
   input  logic        o_mul_ready,
   input  logic        o_mem_ready,
   input  logic        o_bru_ready,
   output logic [31:0] o_pc,
   output logic [3:0]  o_rob,
   output logic [25:0] o_imm,
   output logic [7:0]  o_fid,
   output logic        o_branch,
   output logic        o_load,
   output logic        o_store,
   output logic [19:0] o_cmd,
   output logic        o_err,
   output logic [15:0] o_stall_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  rob;
      logic [25:0] imm;
      logic [7:0]  fid;
      logic        branch;
      logic        load;
      logic        store;
      logic [19:0] cmd;
      logic [3:0]  pipe;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          err_q, err_d;
   logic [15:0]   stall_q, stall_d;

   entry_t     in_entry;
   entry_t     head;
   logic       head_valid;
   logic       bypass_path;
   logic       flush;
   logic       accept;
   logic       multi_hot;
   logic [3:0] pipe_ready;
   logic [3:0] valid_vec;
   logic       fire;
   logic       nop_take;
   logic       take;
   logic       enq_fifo;
   logic       deq_fifo;
   logic       stalled;

   assign flush     = snoop_hit | bco_valid;
   assign i_ready   = (count_q != FULL);
   assign accept    = i_valid & i_ready & ~flush;
   assign multi_hot = (i_pipe & (i_pipe - 4'd1)) != 4'd0;

   // Pack the incoming payload; a multi-hot target keeps only its lowest bit (alu > mul > mem > bru).
   always_comb begin
      in_entry.pc     = i_pc;
      in_entry.rob    = i_rob;
      in_entry.imm    = i_imm;
      in_entry.fid    = i_fid;
      in_entry.branch = i_branch;
      in_entry.load   = i_load;
      in_entry.store  = i_store;
      in_entry.cmd    = i_cmd;
      in_entry.pipe   = i_pipe & (~i_pipe + 4'd1);
   end

`ifdef DECODE_DISPATCH_BYPASS_EN
   // With an empty FIFO the input itself is the head; otherwise the oldest stored entry.
   always_comb begin
      bypass_path = (count_q == '0);
      head_valid  = bypass_path ? i_valid : 1'b1;
      head        = bypass_path ? in_entry : mem_q[rd_ptr_q];
   end
`else
   // The head always comes from FIFO storage, so there is no input-to-output path.
   always_comb begin
      bypass_path = 1'b0;
      head_valid  = (count_q != '0);
      head        = mem_q[rd_ptr_q];
   end
`endif

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_pipe
         assign valid_vec[gi] = head_valid & head.pipe[gi] & ~flush;
      end
   endgenerate

   assign {o_bru_valid, o_mem_valid, o_mul_valid, o_alu_valid} = valid_vec;
   assign pipe_ready = {o_bru_ready, o_mem_ready, o_mul_ready, o_alu_ready};

   // A NOP head (no pipe flag) is consumed immediately without being offered.
   assign fire     = |(valid_vec & pipe_ready);
   assign nop_take = head_valid & (head.pipe == 4'd0) & ~flush;
   assign take     = fire | nop_take;
   assign deq_fifo = take & ~bypass_path;
   assign enq_fifo = accept & ~(bypass_path & take);
   assign stalled  = head_valid & ~flush & (head.pipe != 4'd0) & ~fire;

   // Next-state for pointers, occupancy, sticky error and the stall counter.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq_fifo) wr_ptr_d = wr_ptr_q + AW'(1);
         if (deq_fifo) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(enq_fifo) - (AW+1)'(deq_fifo);
      end
      err_d   = err_q | (accept & multi_hot);
      stall_d = (stalled && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
   end

   // Control state registers; reset overrides flush and enqueue.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         stall_q  <= 16'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         stall_q  <= stall_d;
      end
   end

   // Payload storage is written on enqueue only and is never reset.
   always_ff @(posedge clk) begin
      if (resetn && enq_fifo) mem_q[wr_ptr_q] <= in_entry;
   end

   assign o_pc        = head.pc;
   assign o_rob       = head.rob;
   assign o_imm       = head.imm;
   assign o_fid       = head.fid;
   assign o_branch    = head.branch;
   assign o_load      = head.load;
   assign o_store     = head.store;
   assign o_cmd       = head.cmd;
   assign o_err       = err_q;
   assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_dispatch_ctrl.sv
// Scoreboard bench for decode_dispatch_ctrl (DEPTH=2, default build).
// Stimulus pushes expected issues into a queue.
// A negedge monitor pops and compares an entry on every completed handshake.
`timescale 1ns/1ps
module tb_decode_dispatch_ctrl;

   logic        clk = 1'b0;
   logic        resetn, snoop_hit, bco_valid, i_valid, i_ready;
   logic [31:0] i_pc;
   logic [3:0]  i_rob;
   logic [25:0] i_imm;
   logic [7:0]  i_fid;
   logic        i_branch, i_load, i_store;
   logic [19:0] i_cmd;
   logic [3:0]  i_pipe;
   logic        o_alu_valid, o_mul_valid, o_mem_valid, o_bru_valid;
   logic        o_alu_ready, o_mul_ready, o_mem_ready, o_bru_ready;
   logic [31:0] o_pc;
   logic [3:0]  o_rob;
   logic [25:0] o_imm;
   logic [7:0]  o_fid;
   logic        o_branch, o_load, o_store;
   logic [19:0] o_cmd;
   logic        o_err;
   logic [15:0] o_stall_cnt;

   always #5 clk = ~clk;

   decode_dispatch_ctrl #(.DEPTH(2)) dut (
      .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
      .i_valid(i_valid), .i_ready(i_ready), .i_pc(i_pc), .i_rob(i_rob),
      .i_imm(i_imm), .i_fid(i_fid), .i_branch(i_branch), .i_load(i_load),
      .i_store(i_store), .i_cmd(i_cmd), .i_pipe(i_pipe),
      .o_alu_valid(o_alu_valid), .o_mul_valid(o_mul_valid),
      .o_mem_valid(o_mem_valid), .o_bru_valid(o_bru_valid),
      .o_alu_ready(o_alu_ready), .o_mul_ready(o_mul_ready),
      .o_mem_ready(o_mem_ready), .o_bru_ready(o_bru_ready),
      .o_pc(o_pc), .o_rob(o_rob), .o_imm(o_imm), .o_fid(o_fid),
      .o_branch(o_branch), .o_load(o_load), .o_store(o_store), .o_cmd(o_cmd),
      .o_err(o_err), .o_stall_cnt(o_stall_cnt)
   );

   localparam logic [3:0] P_ALU = 4'b0001;
   localparam logic [3:0] P_MEM = 4'b0100;
   localparam logic [3:0] P_BRU = 4'b1000;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  pipe;
      int          exp_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Payload fields are derived from the pc so every field can be checked.
   function automatic logic [3:0]  f_rob(input logic [31:0] pc); return pc[5:2]; endfunction
   function automatic logic [25:0] f_imm(input logic [31:0] pc); return pc[25:0] ^ 26'h2AAAAAA; endfunction
   function automatic logic [7:0]  f_fid(input logic [31:0] pc); return pc[9:2]; endfunction
   function automatic logic [19:0] f_cmd(input logic [31:0] pc); return pc[19:0] ^ 20'hF0F0F; endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [3:0] pipe);
      i_valid  = 1'b1;
      i_pc     = pc;
      i_rob    = f_rob(pc);
      i_imm    = f_imm(pc);
      i_fid    = f_fid(pc);
      i_branch = pc[2];
      i_load   = pc[3];
      i_store  = pc[4];
      i_cmd    = f_cmd(pc);
      i_pipe   = pipe;
   endtask

   task automatic push(input logic [31:0] pc, input logic [3:0] pipe, input int ec);
      exp_t e;
      e.pc      = pc;
      e.pipe    = pipe;
      e.exp_cyc = ec;
      sb_q.push_back(e);
   endtask

   // Offer one instruction until accepted; optionally expect its issue exactly one cycle later.
   task automatic send(input logic [31:0] pc, input logic [3:0] pipe, input bit do_push,
                       input bit timed, input logic [3:0] exp_pipe);
      bit done;
      done = 1'b0;
      drive(pc, pipe);
      for (int k = 0; k < 50; k++) begin
         if (i_ready) begin
            if (do_push) push(pc, exp_pipe, timed ? cyc + 1 : -1);
            done = 1'b1;
         end
         tick();
         if (done) break;
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
      i_valid = 1'b0;
   endtask

   // Monitor: every completed handshake must match the oldest expected issue.
   always @(negedge clk) begin
      logic [3:0] v, r, hs;
      exp_t       e;
      if (resetn) begin
         v  = {o_bru_valid, o_mem_valid, o_mul_valid, o_alu_valid};
         r  = {o_bru_ready, o_mem_ready, o_mul_ready, o_alu_ready};
         hs = v & r;
         if (snoop_hit | bco_valid) check("valid_in_flush", {28'd0, v}, 32'd0);
         if (v != 4'd0) check("valid_onehot", $countones(v), 32'd1);
         if (hs != 4'd0) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_issue: pc %0h on pipes %b, required no issue", o_pc, hs);
            end else begin
               e = sb_q.pop_front();
               $display("issue pc=%08h pipes=%b cycle=%0d", o_pc, hs, cyc);
               check("issue_pc",    o_pc, e.pc);
               check("issue_pipe",  {28'd0, hs}, {28'd0, e.pipe});
               check("issue_rob",   {28'd0, o_rob}, {28'd0, f_rob(e.pc)});
               check("issue_imm",   {6'd0, o_imm}, {6'd0, f_imm(e.pc)});
               check("issue_fid",   {24'd0, o_fid}, {24'd0, f_fid(e.pc)});
               check("issue_cmd",   {12'd0, o_cmd}, {12'd0, f_cmd(e.pc)});
               check("issue_flags", {29'd0, o_branch, o_load, o_store},
                     {29'd0, e.pc[2], e.pc[3], e.pc[4]});
               if (e.exp_cyc >= 0) check("issue_cycle", cyc, e.exp_cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; snoop_hit = 1'b0; bco_valid = 1'b0; i_valid = 1'b0;
      i_pc = '0; i_rob = '0; i_imm = '0; i_fid = '0; i_branch = 1'b0;
      i_load = 1'b0; i_store = 1'b0; i_cmd = '0; i_pipe = '0;
      o_alu_ready = 1'b0; o_mul_ready = 1'b0; o_mem_ready = 1'b0; o_bru_ready = 1'b0;
      tick();
      tick();
      check("rst_i_ready", i_ready, 1);
      check("rst_valids", {o_bru_valid, o_mem_valid, o_mul_valid, o_alu_valid}, 0);
      check("rst_err", o_err, 0);
      check("rst_stall", o_stall_cnt, 0);
      resetn = 1'b1;
      tick();

      // Three ALU instructions, continuously ready: 1-cycle latency, back to back.
      o_alu_ready = 1'b1;
      send(32'h100, P_ALU, 1, 1, P_ALU);
      send(32'h104, P_ALU, 1, 1, P_ALU);
      send(32'h108, P_ALU, 1, 1, P_ALU);
      repeat (3) tick();
      check("t1_drain", sb_q.size(), 0);
      check("t1_stall", o_stall_cnt, 0);

      // MEM pipe blocked for 5 cycles: FIFO fills after 2, stall count reaches 5.
      o_alu_ready = 1'b0;
      o_mem_ready = 1'b0;
      drive(32'h200, P_MEM);
      check("t2_ready_first", i_ready, 1);
      push(32'h200, P_MEM, -1);
      tick();
      drive(32'h204, P_MEM);
      check("t2_ready_second", i_ready, 1);
      push(32'h204, P_MEM, -1);
      tick();
      drive(32'h208, P_MEM);
      repeat (4) begin
         check("t2_full", i_ready, 0);
         tick();
      end
      check("t2_stall", o_stall_cnt, 5);
      check("t2_full_last", i_ready, 0);
      o_mem_ready = 1'b1;
      tick();
      check("t2_ready_again", i_ready, 1);
      push(32'h208, P_MEM, -1);
      tick();
      i_valid = 1'b0;
      repeat (3) tick();
      check("t2_stall_hold", o_stall_cnt, 5);
      check("t2_drain", sb_q.size(), 0);

      // Full FIFO, then branch-correction flush while a new instruction is offered.
      o_mem_ready = 1'b0;
      o_alu_ready = 1'b0;
      send(32'h300, P_ALU, 0, 0, P_ALU);
      send(32'h304, P_ALU, 0, 0, P_ALU);
      drive(32'h308, P_ALU);
      bco_valid   = 1'b1;
      o_alu_ready = 1'b1;
      #1;
      check("t3_flush_valid", o_alu_valid, 0);
      check("t3_flush_full", i_ready, 0);
      tick();
      bco_valid = 1'b0;
      i_valid   = 1'b0;
      #1;
      check("t3_post_ready", i_ready, 1);
      check("t3_post_valid", o_alu_valid, 0);
      repeat (3) tick();
      check("t3_drain", sb_q.size(), 0);

      // Multi-hot target sets the sticky error and issues on ALU; a NOP is discarded in 1 cycle.
      o_alu_ready = 1'b1; o_mul_ready = 1'b1; o_mem_ready = 1'b1; o_bru_ready = 1'b1;
      send(32'h400, 4'b0011, 1, 1, P_ALU);
      check("t5_err_set", o_err, 1);
      send(32'h404, 4'b0000, 0, 0, 4'b0000);
      send(32'h408, P_ALU, 1, 1, P_ALU);
      repeat (3) tick();
      check("t5_err_sticky", o_err, 1);
      check("t5_drain", sb_q.size(), 0);

      // Snoop hit and reset together: reset values win, error cleared.
      o_alu_ready = 1'b0; o_mul_ready = 1'b0; o_mem_ready = 1'b0; o_bru_ready = 1'b0;
      send(32'h500, P_MEM, 0, 0, P_MEM);
      tick();
      tick();
      check("t4_stall_pre", o_stall_cnt, 8);
      resetn    = 1'b0;
      snoop_hit = 1'b1;
      drive(32'h504, P_MEM);
      tick();
      check("t4_rst_ready", i_ready, 1);
      check("t4_rst_valids", {o_bru_valid, o_mem_valid, o_mul_valid, o_alu_valid}, 0);
      check("t4_rst_err", o_err, 0);
      check("t4_rst_stall", o_stall_cnt, 0);
      resetn    = 1'b1;
      snoop_hit = 1'b0;
      i_valid   = 1'b0;
      tick();
      check("t4_no_entry", o_mem_valid, 0);

      // BRU held not ready for 70000 cycles: stall counter saturates without wrapping.
      send(32'h600, P_BRU, 0, 0, P_BRU);
      repeat (70000) tick();
      check("t6_saturate", o_stall_cnt, 32'h0000FFFF);
      push(32'h600, P_BRU, -1);
      o_bru_ready = 1'b1;
      tick();
      tick();
      check("t6_saturate_hold", o_stall_cnt, 32'h0000FFFF);
      check("t6_drain", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
